fpu_cvt_wb_buffer: RTL and testbench
====================================

FPU_CVT_WB_BUFFER -- requirements
Module: fpu_cvt_wb_buffer

Interface
REQ-001 Parameter XLEN, default 32, integer register width.
REQ-002 Parameter FP_WIDTH_D, default 64, FP register width; SHALL satisfy FP_WIDTH_D >= XLEN.
REQ-003 Parameter DEPTH, default 2, result entries; SHALL be 2 or 4.
REQ-004 i_clk  input  1  sole clock, rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_start  input  1  convert-unit start pulse; one result will follow.
REQ-007 i_valid  input  1  convert-unit result pulse, one cycle.
REQ-008 i_fp_result  input  FP_WIDTH_D  FP result, already NaN-boxed.
REQ-009 i_int_result  input  XLEN  integer result.
REQ-010 i_is_fp_to_int  input  1  result targets integer regfile.
REQ-011 i_flags  input  5  riscv_pkg::fp_flags_t exception flags.
REQ-012 i_dest_reg  input  5  destination register.
REQ-013 i_flush  input  1  discard buffered and in-flight results.
REQ-014 o_can_issue  output  1  upstream may assert i_start this cycle.
REQ-015 o_wb_valid  output  1  head entry presented to writeback.
REQ-016 i_wb_ready  input  1  writeback accepts head entry.
REQ-017 o_wb_is_int  output  1  head targets integer regfile.
REQ-018 o_wb_data  output  FP_WIDTH_D  head data.
REQ-019 o_wb_dest_reg  output  5  head destination.
REQ-020 o_wb_flags  output  5  head flags.
REQ-021 i_fflags_clear  input  1  clear accumulated flags.
REQ-022 o_fflags_accum  output  5  sticky OR of flags of retired entries.
REQ-023 o_overflow  output  1  sticky error: result arrived with no free entry.

Function
REQ-024 Storage SHALL be a DEPTH-entry circular FIFO, read/write pointers wrapping modulo DEPTH, count 0..DEPTH.
REQ-025 Push occurs when i_valid=1 and the result is not being dropped (REQ-031); entry stores is_int, data, dest, flags.
REQ-026 Stored data: is_int=1 -> {zeros, i_int_result} in low XLEN bits; is_int=0 -> i_fp_result unchanged.
REQ-027 Pop occurs when o_wb_valid & i_wb_ready; o_wb_valid = (count != 0); head outputs driven directly from storage (zero input-to-output combinational path).
REQ-028 Latency: result pushed at edge N SHALL present o_wb_valid from cycle N+1 when FIFO was empty.
REQ-029 Simultaneous push and pop SHALL be permitted at any count including DEPTH; count unchanged.
REQ-030 In-flight counter SHALL increment on i_start, decrement on non-dropped-or-dropped i_valid arrival; both same cycle -> unchanged.
REQ-031 Drop counter: on i_flush, drop counter <= in-flight count (including an i_start that same cycle); each i_valid while drop counter > 0 SHALL be discarded and decrement it.
REQ-032 i_flush SHALL empty the FIFO (count<=0, pointers<=0) at the edge; a push and pop that cycle are suppressed; o_fflags_accum unaffected.
REQ-033 o_can_issue = (count + in-flight) < DEPTH, combinational from registers only; 0 while drop counter > 0.
REQ-034 Push with count=DEPTH and no pop SHALL discard the result and set o_overflow until reset.
REQ-035 o_fflags_accum |= head flags on each pop; i_fflags_clear clears it; clear and pop same cycle -> result equals popped flags only.
REQ-036 i_start with o_can_issue=0 is an upstream protocol error; counters still track it.

Reset
REQ-037 On i_rst assertion, asynchronously: count, pointers, in-flight, drop counter, o_fflags_accum, o_overflow <= 0; o_wb_valid=0; o_can_issue=1 after reset.
REQ-038 Reset mid-operation SHALL abandon all entries and in-flight tracking; storage contents need no reset.

Verification
REQ-039 Reset, i_start, i_valid 2 cycles later with int 32'h0000_0007, dest 5, flags 5'b00001, i_wb_ready=1 -> one cycle later o_wb_valid=1, o_wb_is_int=1, o_wb_data=64'h7, dest 5; o_fflags_accum=5'b00001 after pop.
REQ-040 i_wb_ready=0, two FP results 64'hFFFF_FFFF_3F80_0000 then 64'h4000_0000_0000_0000 -> o_can_issue=0 at count 2; drain returns them in order.
REQ-041 FIFO full, third i_valid with i_wb_ready=0 -> o_overflow=1, count stays 2; same cycle with i_wb_ready=1 -> no overflow, count 2, new entry at tail.
REQ-042 i_start then i_flush before result, one entry buffered -> FIFO empty, arriving result discarded, o_wb_valid stays 0, o_can_issue returns 1 the cycle after arrival.
REQ-043 Pop with flags 5'b10000 while i_fflags_clear=1 and accum=5'b00011 -> accum=5'b10000.
REQ-044 Assert i_rst asynchronously mid-cycle with count=2 -> o_wb_valid drops immediately, o_can_issue=1.

Source files
------------

// File: rtl/fpu_cvt_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fpu_cvt_wb_buffer
// Description : Circular result buffer between the FP convert unit and the
//               register writeback port, with flush, sticky flags and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_cvt_wb_buffer #(
    parameter int XLEN       = 32,
    parameter int FP_WIDTH_D = 64,
    parameter int DEPTH      = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_valid,
    input  logic [FP_WIDTH_D-1:0] i_fp_result,
    input  logic [XLEN-1:0]       i_int_result,
    input  logic                  i_is_fp_to_int,
    input  logic [4:0]            i_flags,
    input  logic [4:0]            i_dest_reg,
    input  logic                  i_flush,
    output logic                  o_can_issue,
    output logic                  o_wb_valid,
    input  logic                  i_wb_ready,
    output logic                  o_wb_is_int,
    output logic [FP_WIDTH_D-1:0] o_wb_data,
    output logic [4:0]            o_wb_dest_reg,
    output logic [4:0]            o_wb_flags,
    input  logic                  i_fflags_clear,
    output logic [4:0]            o_fflags_accum,
    output logic                  o_overflow
);

    // DEPTH is 2 or 4, so pointers wrap naturally at their width
    localparam int               PTR_W   = (DEPTH > 2) ? 2 : 1;
    localparam int               CNT_W   = 4;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic                  r_is_int [DEPTH];
    logic [FP_WIDTH_D-1:0] r_data   [DEPTH];
    logic [4:0]            r_dest   [DEPTH];
    logic [4:0]            r_flags  [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_inflight;
    logic [CNT_W-1:0] r_drop;
    logic [4:0]       r_fflags;
    logic             r_overflow;

    logic             w_drop;
    logic             w_keep;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [CNT_W-1:0] w_inflight_nxt;

    assign w_drop = i_valid & (r_drop != '0);
    assign w_keep = i_valid & ~w_drop & ~i_flush;
    assign w_full = (r_count == C_DEPTH);
    assign w_pop  = (r_count != '0) & i_wb_ready & ~i_flush;
    assign w_push = w_keep & (~w_full | w_pop);

    always_comb begin
        w_inflight_nxt = r_inflight;
        if (i_start && !i_valid) begin
            w_inflight_nxt = r_inflight + CNT_W'(1);
        end else if (!i_start && i_valid && (r_inflight != '0)) begin
            w_inflight_nxt = r_inflight - CNT_W'(1);
        end
    end

    // Storage carries no reset; validity is tracked by r_count alone
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_is_int[r_wr_ptr] <= i_is_fp_to_int;
            r_data[r_wr_ptr]   <= i_is_fp_to_int ? FP_WIDTH_D'(i_int_result) : i_fp_result;
            r_dest[r_wr_ptr]   <= i_dest_reg;
            r_flags[r_wr_ptr]  <= i_flags;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            r_fflags   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_inflight <= w_inflight_nxt;

            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_drop   <= w_inflight_nxt;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CNT_W'(1);
                end
                if (w_drop) r_drop <= r_drop - CNT_W'(1);
            end

            if (w_keep && w_full && !w_pop) r_overflow <= 1'b1;

            // A clear coinciding with a pop leaves only the popped flags
            if (i_fflags_clear) begin
                r_fflags <= w_pop ? r_flags[r_rd_ptr] : 5'b0;
            end else if (w_pop) begin
                r_fflags <= r_fflags | r_flags[r_rd_ptr];
            end
        end
    end

    assign o_wb_valid     = (r_count != '0);
    assign o_wb_is_int    = r_is_int[r_rd_ptr];
    assign o_wb_data      = r_data[r_rd_ptr];
    assign o_wb_dest_reg  = r_dest[r_rd_ptr];
    assign o_wb_flags     = r_flags[r_rd_ptr];
    assign o_can_issue    = (r_drop == '0) && ((r_count + r_inflight) < C_DEPTH);
    assign o_fflags_accum = r_fflags;
    assign o_overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fpu_cvt_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_cvt_wb_buffer
// Description : Scoreboard bench for fpu_cvt_wb_buffer with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_cvt_wb_buffer;

    localparam int DEPTH = 2;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic        i_valid;
    logic [63:0] i_fp_result;
    logic [31:0] i_int_result;
    logic        i_is_fp_to_int;
    logic [4:0]  i_flags;
    logic [4:0]  i_dest_reg;
    logic        i_flush;
    logic        o_can_issue;
    logic        o_wb_valid;
    logic        i_wb_ready;
    logic        o_wb_is_int;
    logic [63:0] o_wb_data;
    logic [4:0]  o_wb_dest_reg;
    logic [4:0]  o_wb_flags;
    logic        i_fflags_clear;
    logic [4:0]  o_fflags_accum;
    logic        o_overflow;

    fpu_cvt_wb_buffer #(.XLEN(32), .FP_WIDTH_D(64), .DEPTH(DEPTH)) u_dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_valid        (i_valid),
        .i_fp_result    (i_fp_result),
        .i_int_result   (i_int_result),
        .i_is_fp_to_int (i_is_fp_to_int),
        .i_flags        (i_flags),
        .i_dest_reg     (i_dest_reg),
        .i_flush        (i_flush),
        .o_can_issue    (o_can_issue),
        .o_wb_valid     (o_wb_valid),
        .i_wb_ready     (i_wb_ready),
        .o_wb_is_int    (o_wb_is_int),
        .o_wb_data      (o_wb_data),
        .o_wb_dest_reg  (o_wb_dest_reg),
        .o_wb_flags     (o_wb_flags),
        .i_fflags_clear (i_fflags_clear),
        .o_fflags_accum (o_fflags_accum),
        .o_overflow     (o_overflow)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct packed {
        logic        is_int;
        logic [63:0] data;
        logic [4:0]  dest;
        logic [4:0]  flags;
    } ent_t;

    // m_q: model FIFO contents; sb_q: expected writeback stream for the monitor
    ent_t        m_q[$];
    ent_t        sb_q[$];
    ent_t        mon_e;
    int          m_inflight;
    int          m_drop;
    logic [4:0]  m_acc;
    logic        m_ovf;
    logic        chk_en;
    int          n_tests;
    int          n_fail;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic m_can_issue();
        return (m_drop == 0) && ((m_q.size() + m_inflight) < DEPTH);
    endfunction

    function automatic void model_reset();
        m_q.delete();
        sb_q.delete();
        m_inflight = 0;
        m_drop     = 0;
        m_acc      = 5'b0;
        m_ovf      = 1'b0;
    endfunction

    // Applies the effect of one clock edge given the inputs currently driven
    function automatic void model_step();
        ent_t e;
        bit   pop;
        bit   drop;
        int   inf_n;
        pop   = (m_q.size() != 0) && i_wb_ready && !i_flush;
        drop  = i_valid && (m_drop > 0);
        inf_n = m_inflight;
        if (i_start && !i_valid) inf_n++;
        else if (!i_start && i_valid && m_inflight > 0) inf_n--;
        if (i_fflags_clear) m_acc = pop ? m_q[0].flags : 5'b0;
        else if (pop) m_acc = m_acc | m_q[0].flags;
        if (i_flush) begin
            m_q.delete();
            sb_q.delete();
            m_drop = inf_n;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (i_valid && !drop) begin
                e.is_int = i_is_fp_to_int;
                e.data   = i_is_fp_to_int ? {32'b0, i_int_result} : i_fp_result;
                e.dest   = i_dest_reg;
                e.flags  = i_flags;
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(e);
                    sb_q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (drop) m_drop--;
        end
        m_inflight = inf_n;
    endfunction

    always @(negedge i_clk) begin
        if (!i_rst && chk_en) begin
            chk("wb_valid", 64'(o_wb_valid), 64'(m_q.size() != 0));
            chk("can_issue", 64'(o_can_issue), 64'(m_can_issue()));
            chk("overflow", 64'(o_overflow), 64'(m_ovf));
            chk("fflags_accum", 64'(o_fflags_accum), 64'(m_acc));
            if (o_wb_valid && i_wb_ready && !i_flush) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pop", 64'(1), 64'(0));
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("wb_is_int", 64'(o_wb_is_int), 64'(mon_e.is_int));
                    chk("wb_data", o_wb_data, mon_e.data);
                    chk("wb_dest", 64'(o_wb_dest_reg), 64'(mon_e.dest));
                    chk("wb_flags", 64'(o_wb_flags), 64'(mon_e.flags));
                end
            end
        end
    end

    task automatic step(input logic st, input logic vl, input logic isint,
                        input logic [63:0] fp, input logic [31:0] ir,
                        input logic [4:0] dest, input logic [4:0] flg,
                        input logic fl, input logic rdy, input logic clr);
        i_start = st; i_valid = vl; i_is_fp_to_int = isint;
        i_fp_result = fp; i_int_result = ir; i_dest_reg = dest; i_flags = flg;
        i_flush = fl; i_wb_ready = rdy; i_fflags_clear = clr;
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(0, 0, 0, 64'h0, 32'h0, 5'd0, 5'd0, 0, rdy, 0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_start = 0; i_valid = 0; i_flush = 0; i_wb_ready = 0; i_fflags_clear = 0;
        i_is_fp_to_int = 0; i_fp_result = '0; i_int_result = '0; i_dest_reg = '0; i_flags = '0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    initial begin
        logic st, vl, isint, fl, rdy, clr;
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        do_reset();
        chk_en  = 1'b1;

        // Single integer result end to end
        idle(1);
        step(1, 0, 0, 64'h0, 32'h0, 5'd0, 5'd0, 0, 1, 0);
        idle(1);
        step(0, 1, 1, 64'hDEAD_BEEF_0000_0000, 32'h0000_0007, 5'd5, 5'b00001, 0, 1, 0);
        idle(1);
        idle(1);

        // Two FP results buffered while writeback stalls, then drained in order
        step(1, 0, 0, 64'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0);
        step(1, 0, 0, 64'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 1, 0, 64'hFFFF_FFFF_3F80_0000, 32'h0, 5'd1, 5'b00010, 0, 0, 0);
        step(0, 1, 0, 64'h4000_0000_0000_0000, 32'h0, 5'd2, 5'b00001, 0, 0, 0);
        idle(0);
        idle(1);
        idle(1);
        idle(1);

        // Full FIFO: result with no pop overflows, result with a pop is accepted
        step(1, 0, 0, 64'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0);
        step(1, 0, 0, 64'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 1, 0, 64'h1111, 32'h0, 5'd3, 5'd0, 0, 0, 0);
        step(1, 1, 0, 64'h2222, 32'h0, 5'd4, 5'd0, 0, 0, 0);
        step(0, 1, 0, 64'h3333, 32'h0, 5'd6, 5'd0, 0, 0, 0);
        step(1, 0, 0, 64'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 1, 1, 64'h0, 32'hABCD_0123, 5'd7, 5'b00100, 0, 1, 0);
        idle(1);
        idle(1);
        idle(1);
        do_reset();

        // Flush with one entry buffered and one result in flight
        idle(0);
        step(1, 0, 0, 64'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 1, 0, 64'h5555, 32'h0, 5'd8, 5'b00011, 0, 0, 0);
        step(1, 0, 0, 64'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 0, 0, 64'h0, 32'h0, 5'd0, 5'd0, 1, 1, 0);
        idle(1);
        step(0, 1, 0, 64'h6666, 32'h0, 5'd9, 5'b01000, 0, 1, 0);
        idle(1);
        idle(1);

        // Clear and pop in the same cycle keep only the popped flags
        step(1, 0, 0, 64'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 1, 0, 64'h7777, 32'h0, 5'd10, 5'b00011, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 64'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 1, 0, 64'h8888, 32'h0, 5'd11, 5'b10000, 0, 0, 0);
        step(0, 0, 0, 64'h0, 32'h0, 5'd0, 5'd0, 0, 1, 1);
        idle(1);

        // Randomized traffic respecting the issue protocol
        for (int n = 0; n < 600; n++) begin
            st    = m_can_issue() && ($urandom_range(0, 1) == 1);
            vl    = (m_inflight > 0) && ($urandom_range(0, 2) == 0);
            isint = ($urandom_range(0, 1) == 1);
            fl    = ($urandom_range(0, 29) == 0);
            clr   = ($urandom_range(0, 9) == 0);
            rdy   = ($urandom_range(0, 3) != 0);
            step(st, vl, isint, {$urandom, $urandom}, $urandom, 5'($urandom),
                 5'($urandom), fl, rdy, clr);
        end
        for (int n = 0; n < 8; n++) idle(1);

        // Asynchronous reset mid-cycle while two entries are held
        step(1, 0, 0, 64'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0);
        step(1, 0, 0, 64'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 1, 0, 64'hAAAA, 32'h0, 5'd12, 5'd0, 0, 0, 0);
        step(0, 1, 0, 64'hBBBB, 32'h0, 5'd13, 5'd0, 0, 0, 0);
        #1;
        chk("pre_rst_valid", 64'(o_wb_valid), 64'(1));
        #1;
        i_rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(o_wb_valid), 64'(0));
        chk("async_rst_can_issue", 64'(o_can_issue), 64'(1));
        do_reset();
        idle(1);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
